unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Sequencer for the single-ported unified memory shared by the fetch stage (instruction reads) and the memory stage (data reads and writes). It arbitrates between the two requesters and drives one outstanding command at a time to memory. It returns read data and completion pulses, and generates the per-stage stall signals that freeze the pipeline registers. A branch flush can cancel an in-flight fetch, and a watchdog raises a sticky error if memory never completes.

## Interface
- MAX_WAIT, 31, maximum cycles a command may spend in ISSUE+WAIT before timeout; range 1..255.

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- fetchReq  in  1  instruction read request, held until fetchDone
- fetchAddr  in  16  instruction address, stable while fetchReq high
- fetchFlush  in  1  branch taken; cancels pending or in-flight fetch
- fetchData  out  16  instruction word, valid with fetchDone
- fetchDone  out  1  one-cycle completion pulse for fetch
- fetchStall  out  1  fetchReq & ~fetchDone
- dataRd  in  1  data read request, held until dataDone
- dataWr  in  1  data write request, held until dataDone; dataRd and dataWr never both high
- dataAddr  in  16  data address
- dataWrData  in  16  write data
- dataRdData  out  16  read data, valid with dataDone
- dataDone  out  1  one-cycle completion pulse for data
- dataStall  out  1  (dataRd|dataWr) & ~dataDone
- memRd, memWr  out  1  command strobes to memory, held through ISSUE
- memAddr, memWrData  out  16  registered command address/data
- memStall  in  1  memory cannot accept a command this cycle
- memDone  in  1  memory completion pulse
- memDataIn  in  16  memory read data, valid with memDone
- err  out  1  sticky watchdog timeout flag

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Owner register: DATA or FETCH. Discard flag. 8-bit wait counter.
- IDLE: a data request has priority over a fetch request. Capture the winner's addr/wrdata/rd/wr into command registers, set the owner, clear the counter, and go to ISSUE. A fetch request is ignored in any cycle where fetchFlush=1.
- ISSUE: drive memRd/memWr from the command registers.
  - memStall=0: go to WAIT.
  - memStall=1: stay in ISSUE.
  - owner FETCH and fetchFlush=1: drop strobes and return to IDLE with no done pulse.
- WAIT: strobes low.
  - fetchFlush=1 with owner FETCH sets the discard flag.
  - On memDone: capture memDataIn into the response register and go to RESP.
- RESP: pulse the owner's done, unless discard is set or fetchFlush=1 with owner FETCH. Clear discard and go to IDLE.
  - The requester drops or changes its request in the cycle after done.
  - The RESP→IDLE spacing guarantees the old request is never reissued.
- fetchData and dataRdData both show the response register. For writes, dataRdData is don't-care.
- Watchdog: the counter increments every cycle in ISSUE/WAIT.
  - On reaching MAX_WAIT without memDone: set err, load response 16'h0000, go to RESP. The done pulse is delivered so the pipeline drains.
  - err clears only on reset.
- fetchFlush never affects a DATA-owned transaction.

## Timing
- Reset (rst=0, asynchronous): state IDLE; owner, discard, counter, response and command registers 0; all outputs 0 (stalls follow inputs combinationally once out of reset).
- Request seen in cycle 0 gives ISSUE in cycle 1 (memRd/memWr high). With memStall=0 the state is WAIT in cycle 2.
- memDone in cycle k gives done pulse and data in cycle k+1. The minimum read latency, request to done, is 3 cycles with memDone in cycle 2.
- Back-to-back: the next command can be captured at the earliest in the cycle after RESP, so the earliest next ISSUE is 2 cycles after done.
- Simultaneous fetch and data requests in IDLE: data wins; fetch stays stalled until a later IDLE.
- memDone outside WAIT is ignored.
- Timeout when the counter equals MAX_WAIT: RESP in the next cycle. A memDone arriving in the same cycle as the timeout takes precedence (err not set).

## Test plan
- Single fetch, addr 0x0010, memDone 2 cycles after ISSUE with memDataIn 0xB00F -> fetchDone 1 cycle later, fetchData 0xB00F, fetchStall high until that cycle.
- Simultaneous fetchReq (0x0020) and dataWr (0x0100, 0x1234) -> memWr with addr 0x0100 and data 0x1234 issued first; fetch issued only after dataDone plus 1 cycle.
- memStall held high 3 cycles during ISSUE -> memRd and memAddr held constant for 4 cycles; WAIT entered after memStall drops.
- fetchFlush in WAIT of a fetch, then memDone with 0xDEAD -> no fetchDone; the next fetch issues normally.
- MAX_WAIT=4, memDone never asserted -> err=1 after 4 cycles in ISSUE/WAIT, dataDone pulse with dataRdData 0x0000, err remains 1.
- rst asserted low mid-WAIT -> all outputs 0 immediately and state IDLE; a late memDone is ignored after reset is released.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle joining the fetch stage, the memory stage and the unified memory to the arbiter.
// The master view belongs to the arbiter; the slave view belongs to the pipeline/memory side.
interface unified_mem_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              fetchReq;
    logic [DATA_W-1:0] fetchAddr;
    logic              fetchFlush;
    logic [DATA_W-1:0] fetchData;
    logic              fetchDone;
    logic              fetchStall;

    logic              dataRd;
    logic              dataWr;
    logic [DATA_W-1:0] dataAddr;
    logic [DATA_W-1:0] dataWrData;
    logic [DATA_W-1:0] dataRdData;
    logic              dataDone;
    logic              dataStall;

    logic              memRd;
    logic              memWr;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memWrData;
    logic              memStall;
    logic              memDone;
    logic [DATA_W-1:0] memDataIn;

    modport master (
        input  fetchReq, fetchAddr, fetchFlush,
        input  dataRd, dataWr, dataAddr, dataWrData,
        input  memStall, memDone, memDataIn,
        output fetchData, fetchDone, fetchStall,
        output dataRdData, dataDone, dataStall,
        output memRd, memWr, memAddr, memWrData
    );

    modport slave (
        output fetchReq, fetchAddr, fetchFlush,
        output dataRd, dataWr, dataAddr, dataWrData,
        output memStall, memDone, memDataIn,
        input  fetchData, fetchDone, fetchStall,
        input  dataRdData, dataDone, dataStall,
        input  memRd, memWr, memAddr, memWrData
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-outstanding-command sequencer for the unified memory shared by fetch and data stages,
// with branch-flush cancellation of fetches and a sticky watchdog on memory completion.
module unified_mem_arbiter #(
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.master bus,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_DATA = 1'b0, OWN_FETCH = 1'b1} owner_t;

    state_t            state;
    state_t            stateNext;
    owner_t            owner;
    logic              discard;
    logic [7:0]        waitCnt;
    logic [DATA_W-1:0] cmdAddr;
    logic [DATA_W-1:0] cmdWrData;
    logic              cmdRd;
    logic              cmdWr;
    logic [DATA_W-1:0] resp;

    logic grantData;
    logic grantFetch;
    logic flushHit;
    logic memAck;
    logic timeout;

    assign grantData  = bus.dataRd || bus.dataWr;
    assign grantFetch = !grantData && bus.fetchReq && !bus.fetchFlush;
    assign flushHit   = bus.fetchFlush && (owner == OWN_FETCH);
    assign memAck     = (state == WAIT) && bus.memDone;
    // A cancelled fetch in ISSUE leaves for IDLE, so it never counts as a timeout.
    assign timeout    = ((state == ISSUE && !flushHit) || state == WAIT)
                        && (waitCnt == 8'(MAX_WAIT)) && !memAck;

    always_comb begin
        stateNext = state;
        bus.memRd = 1'b0;
        bus.memWr = 1'b0;
        case (state)
            IDLE: begin
                if (grantData || grantFetch) stateNext = ISSUE;
            end
            ISSUE: begin
                if (!flushHit) begin
                    bus.memRd = cmdRd;
                    bus.memWr = cmdWr;
                end
                if (flushHit)          stateNext = IDLE;
                else if (timeout)      stateNext = RESP;
                else if (!bus.memStall) stateNext = WAIT;
            end
            WAIT: begin
                if (memAck || timeout) stateNext = RESP;
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_DATA;
            discard   <= 1'b0;
            waitCnt   <= 8'd0;
            cmdAddr   <= '0;
            cmdWrData <= '0;
            cmdRd     <= 1'b0;
            cmdWr     <= 1'b0;
            resp      <= '0;
            err       <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (grantData) begin
                        owner     <= OWN_DATA;
                        cmdAddr   <= bus.dataAddr;
                        cmdWrData <= bus.dataWrData;
                        cmdRd     <= bus.dataRd;
                        cmdWr     <= bus.dataWr;
                        waitCnt   <= 8'd0;
                    end else if (grantFetch) begin
                        owner     <= OWN_FETCH;
                        cmdAddr   <= bus.fetchAddr;
                        cmdWrData <= '0;
                        cmdRd     <= 1'b1;
                        cmdWr     <= 1'b0;
                        waitCnt   <= 8'd0;
                    end
                end
                ISSUE, WAIT: begin
                    waitCnt <= waitCnt + 8'd1;
                    // Memory still owes a response, so a flushed fetch rides it out and is muted.
                    if (state == WAIT && flushHit) discard <= 1'b1;
                    if (memAck) begin
                        resp <= bus.memDataIn;
                    end else if (timeout) begin
                        resp <= '0;
                        err  <= 1'b1;
                    end
                end
                RESP: begin
                    discard <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.memAddr    = cmdAddr;
    assign bus.memWrData  = cmdWrData;
    assign bus.fetchData  = resp;
    assign bus.dataRdData = resp;
    assign bus.dataDone   = (state == RESP) && (owner == OWN_DATA);
    assign bus.fetchDone  = (state == RESP) && (owner == OWN_FETCH) && !discard && !bus.fetchFlush;
    // Stalls are forced low while reset is asserted so every output reads zero during reset.
    assign bus.fetchStall = rst && bus.fetchReq && !bus.fetchDone;
    assign bus.dataStall  = rst && grantData && !bus.dataDone;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench: the bench plays pipeline and memory, and a plain memory array plus
// transaction-level timing rules predict every strobe, pulse, data word and error flag.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
    localparam int MW     = 4;
    localparam int RESP_T = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err;

    unified_mem_arbiter_if #(.DATA_W(16)) bus ();

    unified_mem_arbiter #(.DATA_W(16), .MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;
    bit expErr = 1'b0;
    logic [15:0] memModel [logic [15:0]];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] memRead(input logic [15:0] a);
        if (memModel.exists(a)) return memModel[a];
        return a ^ 16'h5A3C;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic driveIdle();
        bus.fetchReq = 1'b0; bus.fetchAddr = 16'h0; bus.fetchFlush = 1'b0;
        bus.dataRd = 1'b0; bus.dataWr = 1'b0; bus.dataAddr = 16'h0; bus.dataWrData = 16'h0;
        bus.memStall = 1'b0; bus.memDone = 1'b0; bus.memDataIn = 16'h0;
    endtask

    task automatic checkStalls(input bit fDone, input bit dDone);
        checkVal("fetchStall", 32'(bus.fetchStall), 32'(bus.fetchReq && !fDone));
        checkVal("dataStall", 32'(bus.dataStall), 32'((bus.dataRd || bus.dataWr) && !dDone));
    endtask

    task automatic checkResetOutputs();
        checkVal("rstStrobe", 32'({bus.memRd, bus.memWr}), 32'd0);
        checkVal("rstMemAddr", 32'(bus.memAddr), 32'd0);
        checkVal("rstMemWrData", 32'(bus.memWrData), 32'd0);
        checkVal("rstFetchData", 32'(bus.fetchData), 32'd0);
        checkVal("rstDataRdData", 32'(bus.dataRdData), 32'd0);
        checkVal("rstDone", 32'({bus.fetchDone, bus.dataDone}), 32'd0);
        checkVal("rstStall", 32'({bus.fetchStall, bus.dataStall}), 32'd0);
        checkVal("rstErr", 32'(err), 32'd0);
    endtask

    // kind: 0 fetch read, 1 data read, 2 data write. s = stalled ISSUE cycles,
    // d = cycle (counted from first ISSUE cycle) of memDone, flushT = cycle of a fetchFlush pulse.
    task automatic runCmd(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                          input int s, input int d, input int flushT,
                          input bit holdFetch, input logic [15:0] fAddr);
        bit isFetch, isWr, fl, inIssue, disc, dropF, timedOut, doneOk, cancelled, finished;
        logic [15:0] rdVal;
        isFetch = (kind == 0);
        isWr = (kind == 2);
        disc = 1'b0; dropF = 1'b0; timedOut = 1'b0; cancelled = 1'b0; finished = 1'b0;
        rdVal = 16'h0;

        bus.fetchReq   = isFetch || holdFetch;
        bus.fetchAddr  = isFetch ? addr : fAddr;
        bus.fetchFlush = 1'b0;
        bus.dataRd     = (kind == 1);
        bus.dataWr     = isWr;
        bus.dataAddr   = isFetch ? 16'h0 : addr;
        bus.dataWrData = isWr ? wdata : 16'h0;
        bus.memStall   = 1'($urandom_range(0, 1));
        bus.memDone    = 1'($urandom_range(0, 1));
        bus.memDataIn  = 16'($urandom);
        #1;
        checkVal("idleStrobe", 32'({bus.memRd, bus.memWr}), 32'd0);
        checkVal("idleDone", 32'({bus.fetchDone, bus.dataDone}), 32'd0);
        checkStalls(1'b0, 1'b0);
        checkVal("err", 32'(err), 32'(expErr));
        step();

        for (int t = 0; t <= MW && !finished; t++) begin
            inIssue = (t <= s);
            fl = (t == flushT);
            if (dropF) bus.fetchReq = 1'b0;
            bus.fetchFlush = fl;
            bus.memStall = inIssue ? (t < s) : 1'($urandom_range(0, 1));
            bus.memDone = inIssue ? 1'($urandom_range(0, 1)) : (t == d);
            if (!inIssue && t == d && !isWr) rdVal = memRead(addr);
            bus.memDataIn = (!inIssue && t == d && !isWr) ? rdVal : 16'($urandom);
            #1;
            if (inIssue) begin
                checkVal("issueRd", 32'(bus.memRd), 32'(!isWr && !(isFetch && fl)));
                checkVal("issueWr", 32'(bus.memWr), 32'(isWr));
                checkVal("issueAddr", 32'(bus.memAddr), 32'(addr));
                if (isWr) checkVal("issueWrData", 32'(bus.memWrData), 32'(wdata));
            end else begin
                checkVal("waitStrobe", 32'({bus.memRd, bus.memWr}), 32'd0);
            end
            checkVal("busyDone", 32'({bus.fetchDone, bus.dataDone}), 32'd0);
            checkStalls(1'b0, 1'b0);
            checkVal("err", 32'(err), 32'(expErr));

            if (isFetch && fl) dropF = 1'b1;
            if (isFetch && fl && inIssue) begin
                cancelled = 1'b1;
                finished = 1'b1;
            end else begin
                if (isFetch && fl) disc = 1'b1;
                if (!inIssue && t == d) begin
                    if (isWr) memModel[addr] = wdata;
                    finished = 1'b1;
                end else if (t == MW) begin
                    timedOut = 1'b1;
                    finished = 1'b1;
                end
            end
            step();
        end

        if (cancelled) begin
            bus.fetchReq = 1'b0;
            bus.fetchFlush = 1'b0;
        end else begin
            if (dropF) bus.fetchReq = 1'b0;
            fl = (flushT == RESP_T);
            bus.fetchFlush = fl;
            bus.memStall = 1'($urandom_range(0, 1));
            bus.memDone = 1'($urandom_range(0, 1));
            bus.memDataIn = 16'($urandom);
            if (timedOut) begin
                expErr = 1'b1;
                rdVal = 16'h0;
            end
            doneOk = !(isFetch && (disc || fl));
            #1;
            checkVal("fetchDone", 32'(bus.fetchDone), 32'(isFetch && doneOk));
            checkVal("dataDone", 32'(bus.dataDone), 32'(!isFetch));
            if (isFetch && doneOk) checkVal("fetchData", 32'(bus.fetchData), 32'(rdVal));
            if (kind == 1) checkVal("dataRdData", 32'(bus.dataRdData), 32'(rdVal));
            checkVal("respStrobe", 32'({bus.memRd, bus.memWr}), 32'd0);
            checkStalls(isFetch && doneOk, !isFetch);
            checkVal("err", 32'(err), 32'(expErr));
            step();
            bus.fetchFlush = 1'b0;
            if (isFetch) bus.fetchReq = 1'b0;
            else begin
                bus.dataRd = 1'b0;
                bus.dataWr = 1'b0;
            end
        end
    endtask

    task automatic randomPhase(input int count, input bit allowTimeout);
        bit pend;
        bit hold;
        logic [15:0] pendAddr;
        logic [15:0] addr;
        int kind, s, d, flushT, r;
        pend = 1'b0;
        pendAddr = 16'h0;
        for (int i = 0; i < count; i++) begin
            kind = $urandom_range(0, 2);
            addr = 16'($urandom_range(0, 15));
            s = $urandom_range(0, 3);
            d = $urandom_range(s + 1, MW);
            if (allowTimeout && $urandom_range(0, 4) == 0) d = MW + 3;
            r = $urandom_range(0, 9);
            flushT = (r < 5) ? -1 : (r < 8) ? $urandom_range(0, MW) : RESP_T;
            hold = 1'b0;
            if (kind == 0) begin
                if (pend) addr = pendAddr;
                pend = 1'b0;
            end else begin
                hold = pend || ($urandom_range(0, 3) == 0);
                if (hold && !pend) begin
                    pendAddr = 16'($urandom_range(0, 15));
                    pend = 1'b1;
                end
            end
            runCmd(kind, addr, 16'($urandom), s, d, flushT, hold, pendAddr);
        end
    endtask

    initial begin
        driveIdle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs();
        #2 rst = 1'b1;
        step();

        // Single fetch with fixed memory content.
        memModel[16'h0010] = 16'hB00F;
        runCmd(0, 16'h0010, 16'h0, 0, 2, -1, 1'b0, 16'h0);
        // Data write beats a simultaneous fetch; the fetch is issued afterwards.
        runCmd(2, 16'h0100, 16'h1234, 0, 1, -1, 1'b1, 16'h0020);
        runCmd(0, 16'h0020, 16'h0, 0, 1, -1, 1'b0, 16'h0);
        runCmd(1, 16'h0100, 16'h0, 1, 3, -1, 1'b0, 16'h0);
        // Long memStall, with memDone landing on the timeout cycle.
        runCmd(1, 16'h0200, 16'h0, 3, 4, -1, 1'b0, 16'h0);
        // Flush in WAIT discards the response; the following fetch is normal.
        memModel[16'h0300] = 16'hDEAD;
        runCmd(0, 16'h0300, 16'h0, 0, 3, 1, 1'b0, 16'h0);
        runCmd(0, 16'h0302, 16'h0, 0, 1, -1, 1'b0, 16'h0);
        // Flush in ISSUE cancels, flush in RESP mutes, flush never touches data.
        runCmd(0, 16'h0500, 16'h0, 2, 3, 1, 1'b0, 16'h0);
        runCmd(0, 16'h0600, 16'h0, 0, 1, RESP_T, 1'b0, 16'h0);
        runCmd(1, 16'h0010, 16'h0, 0, 2, 1, 1'b0, 16'h0);
        // A fetch presented together with a flush in IDLE is not captured.
        bus.fetchReq = 1'b1; bus.fetchAddr = 16'h0700; bus.fetchFlush = 1'b1;
        #1;
        checkVal("flushIdleStrobe", 32'({bus.memRd, bus.memWr}), 32'd0);
        step();
        runCmd(0, 16'h0700, 16'h0, 0, 1, -1, 1'b0, 16'h0);

        randomPhase(60, 1'b0);

        // Memory never answers: watchdog fires, zero data, sticky err.
        runCmd(1, 16'h0400, 16'h0, 0, MW + 3, -1, 1'b0, 16'h0);
        runCmd(0, 16'h0010, 16'h0, 0, 1, -1, 1'b0, 16'h0);

        randomPhase(60, 1'b1);

        // Asynchronous reset in the middle of WAIT.
        driveIdle();
        bus.dataRd = 1'b1; bus.dataAddr = 16'h0710;
        bus.fetchReq = 1'b1; bus.fetchAddr = 16'h0720;
        step();
        bus.memStall = 1'b0;
        step();
        #2 rst = 1'b0;
        #1;
        checkResetOutputs();
        driveIdle();
        step();
        step();
        rst = 1'b1;
        expErr = 1'b0;
        bus.memDone = 1'b1; bus.memDataIn = 16'hBEEF;
        #1;
        checkVal("lateDone", 32'({bus.fetchDone, bus.dataDone}), 32'd0);
        step();
        bus.memDone = 1'b0;
        #1;
        checkVal("postRstDone", 32'({bus.fetchDone, bus.dataDone}), 32'd0);
        checkVal("postRstStrobe", 32'({bus.memRd, bus.memWr}), 32'd0);
        checkVal("postRstData", 32'(bus.dataRdData), 32'd0);
        checkVal("postRstErr", 32'(err), 32'd0);
        step();
        runCmd(1, 16'h0100, 16'h0, 0, 2, -1, 1'b0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL simTimeLimit got=running expected=finished");
        $fatal(1, "time limit");
    end
endmodule
